hadamard_collector: RTL and testbench

- Downstream of the 4-lane complex SFP Hadamard/butterfly stage. Captures each 4-lane result beat when the stage's done pulse fires.
- Accumulates a frame of 4*FRAME_BEATS complex points in a ping-pong buffer and undoes the lane/beat stride.
- Streams points one per cycle, in natural index order, to the next FFT stage over a valid/ready interface.
- Lets the butterfly pipeline run at full rate while the consumer applies backpressure.

---
 rtl/hadamard_collector.sv | 137 +++++++++++++
 tb/tb_hadamard_collector.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/hadamard_collector.sv
`default_nettype none
// hadamard_collector: ping-pong frame buffer that captures 4-lane butterfly beats, undoes the
// lane/beat stride and streams points over valid/ready. Optional: HADAMARD_COLLECT_BITREV_EN.
module hadamard_collector #(
  parameter int expWidth    = 4,
  parameter int sigWidth    = 4,
  parameter int formatWidth = 9,
  parameter int FRAME_BEATS = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [formatWidth*4-1:0] in_real,
  input  logic [formatWidth*4-1:0] in_imag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [formatWidth-1:0]   out_real,
  output logic [formatWidth-1:0]   out_imag,
  output logic                     out_last,
  output logic                     overflow,
  input  logic                     ovf_clr
);

  localparam int N  = 4 * FRAME_BEATS;
  localparam int BW = (FRAME_BEATS > 1) ? $clog2(FRAME_BEATS) : 1;
  localparam int IW = $clog2(N);

  logic [formatWidth-1:0] mem_re_q [2][N];
  logic [formatWidth-1:0] mem_re_d [2][N];
  logic [formatWidth-1:0] mem_im_q [2][N];
  logic [formatWidth-1:0] mem_im_d [2][N];

  logic          wr_bank_q, wr_bank_d;
  logic [BW-1:0] wr_beat_q, wr_beat_d;
  logic          rd_bank_q, rd_bank_d;
  logic [IW-1:0] rd_idx_q,  rd_idx_d;
  logic [1:0]    bank_full_q, bank_full_d;
  logic          overflow_q, overflow_d;

  logic          wr_accept, wr_drop, wr_last, rd_fire, rd_last;
  logic [1:0]    full_set, full_clr;
  logic [IW-1:0] wr_addr;
  logic [IW-1:0] rd_addr;

  assign wr_accept = in_valid & ~bank_full_q[wr_bank_q];
  assign wr_drop   = in_valid &  bank_full_q[wr_bank_q];
  assign wr_last   = (wr_beat_q == BW'(FRAME_BEATS - 1));
  assign rd_last   = (rd_idx_q == IW'(N - 1));
  assign rd_fire   = out_valid & out_ready;

  // Lane l of beat b lands at natural index l*FRAME_BEATS+b, undoing the butterfly stride.
  always_comb begin
    mem_re_d    = mem_re_q;
    mem_im_d    = mem_im_q;
    wr_bank_d   = wr_bank_q;
    wr_beat_d   = wr_beat_q;
    full_set    = 2'b00;
    wr_addr     = '0;
    if (wr_accept) begin
      for (int l = 0; l < 4; l++) begin
        wr_addr = IW'(l * FRAME_BEATS) + IW'(wr_beat_q);
        mem_re_d[wr_bank_q][wr_addr] = in_real[l*formatWidth +: formatWidth];
        mem_im_d[wr_bank_q][wr_addr] = in_imag[l*formatWidth +: formatWidth];
      end
      if (wr_last) begin
        full_set[wr_bank_q] = 1'b1;
        wr_bank_d           = ~wr_bank_q;
        wr_beat_d           = '0;
      end else begin
        wr_beat_d = wr_beat_q + BW'(1);
      end
    end
  end

  always_comb begin
    rd_bank_d = rd_bank_q;
    rd_idx_d  = rd_idx_q;
    full_clr  = 2'b00;
    if (rd_fire) begin
      if (rd_last) begin
        full_clr[rd_bank_q] = 1'b1;
        rd_bank_d           = ~rd_bank_q;
        rd_idx_d            = '0;
      end else begin
        rd_idx_d = rd_idx_q + IW'(1);
      end
    end
  end

  // Set and clear always target different banks; a new drop beats a same-cycle clear.
  always_comb begin
    bank_full_d = (bank_full_q | full_set) & ~full_clr;
    overflow_d  = (overflow_q & ~ovf_clr) | wr_drop;
  end

`ifdef HADAMARD_COLLECT_BITREV_EN
  for (genvar i = 0; i < IW; i++) begin : g_bitrev
    assign rd_addr[i] = rd_idx_q[IW-1-i];
  end
`else
  assign rd_addr = rd_idx_q;
`endif

  assign out_valid = bank_full_q[rd_bank_q];
  assign out_real  = mem_re_q[rd_bank_q][rd_addr];
  assign out_imag  = mem_im_q[rd_bank_q][rd_addr];
  assign out_last  = out_valid & rd_last;
  assign overflow  = overflow_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int b = 0; b < 2; b++) begin
        for (int a = 0; a < N; a++) begin
          mem_re_q[b][a] <= '0;
          mem_im_q[b][a] <= '0;
        end
      end
      wr_bank_q   <= 1'b0;
      wr_beat_q   <= '0;
      rd_bank_q   <= 1'b0;
      rd_idx_q    <= '0;
      bank_full_q <= 2'b00;
      overflow_q  <= 1'b0;
    end else begin
      mem_re_q    <= mem_re_d;
      mem_im_q    <= mem_im_d;
      wr_bank_q   <= wr_bank_d;
      wr_beat_q   <= wr_beat_d;
      rd_bank_q   <= rd_bank_d;
      rd_idx_q    <= rd_idx_d;
      bank_full_q <= bank_full_d;
      overflow_q  <= overflow_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hadamard_collector.sv
`default_nettype none
// tb_hadamard_collector: directed checks of reorder, backpressure, ping-pong overflow and reset.
module tb_hadamard_collector;
  localparam int FW = 9;
  localparam int FB = 4;
  localparam int N  = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic [FW*4-1:0] in_real = '0;
  logic [FW*4-1:0] in_imag = '0;
  logic          out_ready = 1'b0;
  logic          ovf_clr = 1'b0;
  logic          out_valid, out_last, overflow;
  logic [FW-1:0] out_real, out_imag;

  int n_tests = 0;
  int n_fail  = 0;

  hadamard_collector #(.expWidth(4), .sigWidth(4), .formatWidth(FW), .FRAME_BEATS(FB)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_real(in_real), .in_imag(in_imag),
    .out_valid(out_valid), .out_ready(out_ready), .out_real(out_real), .out_imag(out_imag),
    .out_last(out_last), .overflow(overflow), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input int b, input int base);
    in_valid = 1'b1;
    for (int l = 0; l < 4; l++) begin
      in_real[l*FW +: FW] = FW'(base + l*4 + b);
      in_imag[l*FW +: FW] = 9'h100 | FW'(base + l*4 + b);
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input int base, input bit chk);
    for (int b = 0; b < FB; b++) begin
      if (chk && b == FB-1) check_eq("pre_last_valid", 32'(out_valid), 0);
      send_beat(b, base);
    end
    if (chk) check_eq("valid_rise", 32'(out_valid), 1);
  endtask

  function automatic int exp_idx(input int k);
    int r;
`ifdef HADAMARD_COLLECT_BITREV_EN
    r = {28'd0, k[0], k[1], k[2], k[3]};
`else
    r = k;
`endif
    return r;
  endfunction

  // mode 0: ready held high; mode 1: ready pattern 1,0,0 repeating
  task automatic drain(input int base, input int mode);
    int k, cyc, e;
    k = 0;
    cyc = 0;
    while (k < N && cyc < 100) begin
      out_ready = (mode == 0) || (cyc % 3 == 0);
      e = base + exp_idx(k);
      check_eq("drain_valid", 32'(out_valid), 1);
      check_eq("drain_real", 32'(out_real), e);
      check_eq("drain_imag", 32'(out_imag), 32'h100 | e);
      check_eq("drain_last", 32'(out_last), (k == N-1) ? 1 : 0);
      if (out_ready) k++;
      cyc++;
      tick();
    end
    if (k < N) check_eq("drain_timeout", k, N);
  endtask

  initial begin
    repeat (3) tick();
    rst = 1'b1;
    tick();
    repeat (20) begin
      check_eq("idle", {out_valid, out_last, overflow, out_real, out_imag}, 0);
      tick();
    end

    // natural-order reorder with ready held high
    out_ready = 1'b1;
    send_frame(0, 1'b1);
    drain(0, 0);
    check_eq("reorder_done_valid", 32'(out_valid), 0);

    // backpressure
    out_ready = 1'b0;
    send_frame(0, 1'b1);
    drain(0, 1);
    out_ready = 1'b0;
    check_eq("bp_done_valid", 32'(out_valid), 0);

    // ping-pong fill, then drops
    for (int i = 0; i < 12; i++) begin
      send_beat(i % 4, (i / 4) * 32);
      check_eq("ovf_fill", 32'(overflow), (i >= 8) ? 1 : 0);
    end
    check_eq("ovf_hold_real", 32'(out_real), 0);
    drain(0, 0);
    drain(32, 0);
    out_ready = 1'b0;
    check_eq("pp_done_valid", 32'(out_valid), 0);
    check_eq("ovf_sticky", 32'(overflow), 1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check_eq("ovf_cleared", 32'(overflow), 0);

    // clear versus set on the same edge
    for (int i = 0; i < 8; i++) send_beat(i % 4, (i / 4) * 32);
    check_eq("cvs_no_drop", 32'(overflow), 0);
    send_beat(0, 64);
    check_eq("cvs_drop", 32'(overflow), 1);
    ovf_clr = 1'b1;
    send_beat(1, 64);
    ovf_clr = 1'b0;
    check_eq("cvs_set_wins", 32'(overflow), 1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check_eq("cvs_clear", 32'(overflow), 0);

    // reset mid-frame
    rst = 1'b0;
    #2;
    rst = 1'b1;
    tick();
    check_eq("rst1_valid", 32'(out_valid), 0);
    send_beat(0, 48);
    send_beat(1, 48);
    rst = 1'b0;
    #2;
    check_eq("rst_async_valid", 32'(out_valid), 0);
    rst = 1'b1;
    tick();
    check_eq("rst_mid_valid", 32'(out_valid), 0);
    check_eq("rst_mid_data", {out_real, out_imag, out_last, overflow}, 0);
    out_ready = 1'b1;
    send_frame(80, 1'b1);
    drain(80, 0);
    check_eq("fresh_done_valid", 32'(out_valid), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
